// File: rtl/tresp_pkg.sv
// ---------------------------------------------------------------------------
// tresp_pkg
// Shared types and constants for the toggle req/ack responder.
//   - tresp_state_e : FSM states (S_RDBK only exists when the
//                     TRESP_WR_READBACK_EN macro is defined)
//   - DS_* lane codes for the {hi, lo} byte select
//   - RD_LAT_MAX / CNT_W : read-latency bound and latency counter width
// ---------------------------------------------------------------------------
package tresp_pkg;

    // Largest RAM read latency the responder supports.
    localparam int RD_LAT_MAX = 4;

    // The counter is loaded with the full read latency (the capture edge is
    // one edge after mem_q first becomes valid), so it must hold RD_LAT_MAX.
    localparam int CNT_W = $clog2(RD_LAT_MAX + 1);

    localparam logic [1:0] DS_NONE = 2'b00;
    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_WORD = 2'b11;

`ifdef TRESP_WR_READBACK_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_RDBK = 2'd3
    } tresp_state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } tresp_state_e;
`endif

    function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
        return CNT_W'(lat);
    endfunction

endpackage

// File: rtl/tresp_lat_cnt.sv
// ---------------------------------------------------------------------------
// tresp_lat_cnt
// Loadable down-counter with zero flag, used to time RAM read latency.
//   clk, rst_n : clock / async active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (saturates at zero)
//   zero       : counter is zero
// ---------------------------------------------------------------------------
module tresp_lat_cnt
    import tresp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/toggle_req_responder.sv
// ---------------------------------------------------------------------------
// toggle_req_responder
// Responder end of the toggle req/ack memory-port protocol, backed by a
// synchronous block-RAM port. A request is pending whenever req != ack; it
// is serviced against the RAM and answered by making ack equal req again.
//
// Ports:
//   clk_49m, reset      : clock, async active-low reset
//   req / ack           : request / acknowledge toggles
//   a, ds, we, d        : word address, byte lanes {hi,lo}, write flag, data
//   q                   : read data (held until the next read completes)
//   busy                : request in service
//   mem_addr/we/be/d    : registered RAM command
//   mem_q               : RAM read data, RD_LATENCY cycles after mem_addr
//
// Build option: TRESP_WR_READBACK_EN -- when defined every write is followed
// by a read of the same address so q returns the post-write word.
// ---------------------------------------------------------------------------
module toggle_req_responder
    import tresp_pkg::*;
#(
    parameter int AW         = 15,
    parameter int DW         = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic            clk_49m,
    input  logic            reset,
    input  logic            req,
    output logic            ack,
    input  logic [AW-1:0]   a,
    input  logic [1:0]      ds,
    input  logic            we,
    input  logic [DW-1:0]   d,
    output logic [DW-1:0]   q,
    output logic            busy,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [1:0]      mem_be,
    output logic [DW-1:0]   mem_d,
    input  logic [DW-1:0]   mem_q
);

    tresp_state_e state_q, state_d;

    logic            ack_q, ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [1:0]      mem_be_q, mem_be_d;
    logic [DW-1:0]   mem_d_q, mem_d_d;
    // Current WAIT pass is a read whose result goes to q.
    logic            rd_q, rd_d;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    // req is already in the clk_49m domain.
    logic pending;
    assign pending = req ^ ack_q;

    tresp_lat_cnt u_lat_cnt (
        .clk      (clk_49m),
        .rst_n    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pending) begin
`ifdef TRESP_WR_READBACK_EN
                    state_d = we ? S_RDBK : S_WAIT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
`ifdef TRESP_WR_READBACK_EN
            S_RDBK:  state_d = S_WAIT;
`endif
            S_WAIT:  if (cnt_zero) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        ack_d      = ack_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_be_d   = mem_be_q;
        mem_d_d    = mem_d_q;
        rd_d       = rd_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pending) begin
                    mem_addr_d = a;
                    mem_d_d    = d;
                    busy_d     = 1'b1;
                    rd_d       = ~we;
                    cnt_load   = 1'b1;
                    if (we) begin
                        mem_we_d = 1'b1;
                        mem_be_d = ds;
                        // Zero count: one WAIT cycle then DONE.
                        cnt_val  = '0;
                    end else begin
                        mem_be_d = DS_NONE;
                        // Capture lands one edge after mem_q turns valid.
                        cnt_val  = lat_to_cnt(RD_LATENCY);
                    end
                end
            end
`ifdef TRESP_WR_READBACK_EN
            // Write strobe has just been issued; turn the port into a read of
            // the same address so the RAM returns the post-write word.
            S_RDBK: begin
                mem_be_d = DS_NONE;
                rd_d     = 1'b1;
                cnt_load = 1'b1;
                cnt_val  = lat_to_cnt(RD_LATENCY);
            end
`endif
            S_WAIT: begin
                if (cnt_zero) begin
                    if (rd_q)
                        rdata_d = mem_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_DONE: begin
                // Match req rather than blindly toggling: a second toggle
                // from a misbehaving initiator is dropped, not queued.
                ack_d  = req;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= '0;
            mem_d_q    <= '0;
            rd_q       <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_d_q    <= mem_d_d;
            rd_q       <= rd_d;
        end
    end

    assign ack      = ack_q;
    assign q        = rdata_q;
    assign busy     = busy_q;
    assign mem_addr = mem_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_be   = mem_be_q;
    assign mem_d    = mem_d_q;

endmodule

// File: tb/tb_toggle_req_responder.sv
// Scoreboard bench for toggle_req_responder (RD_LATENCY=2). Stimulus pushes
// expected responses / RAM writes; a negedge monitor pops and compares.
module tb_toggle_req_responder;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int L  = 2;
`ifdef TRESP_WR_READBACK_EN
    localparam int WR_LAT = L + 3;
    localparam bit RB     = 1'b1;
`else
    localparam int WR_LAT = 2;
    localparam bit RB     = 1'b0;
`endif

    localparam logic [15:0] TBL [8] = '{16'h0F00, 16'h1E11, 16'h2D22, 16'h3C33,
                                        16'h4B44, 16'h5A55, 16'h6966, 16'h7877};

    logic clk_49m, reset, req, ack, we, busy, mem_we;
    logic [AW-1:0] a, mem_addr;
    logic [1:0]    ds, mem_be;
    logic [DW-1:0] d, q, mem_d, mem_q;

    toggle_req_responder #(.AW(AW), .DW(DW), .RD_LATENCY(L)) dut (
        .clk_49m(clk_49m), .reset(reset), .req(req), .ack(ack), .a(a), .ds(ds),
        .we(we), .d(d), .q(q), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_d(mem_d), .mem_q(mem_q)
    );

    initial clk_49m = 1'b0;
    always #5 clk_49m = ~clk_49m;

    int cyc = 0;
    always @(posedge clk_49m) cyc <= cyc + 1;

    // Synchronous RAM, read-first, L-cycle read pipeline.
    logic [15:0] ram [0:1023];
    logic [15:0] rd_pipe [L];
    logic        loaded = 1'b0;
    always @(posedge clk_49m) begin
        if (!loaded) begin
            for (int i = 0; i < 8; i++) ram[10'h200 + i] <= TBL[i];
            ram[10'h123] <= 16'h0000;
            ram[10'h040] <= 16'h0000;
            loaded <= 1'b1;
        end else if (mem_we) begin
            if (mem_be[0]) ram[mem_addr[9:0]][7:0]  <= mem_d[7:0];
            if (mem_be[1]) ram[mem_addr[9:0]][15:8] <= mem_d[15:8];
        end
        rd_pipe[0] <= ram[mem_addr[9:0]];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_q = rd_pipe[L-1];

    typedef struct { logic [15:0] q; int lat; int det; } rsp_t;
    typedef struct { logic [14:0] a; logic [1:0] be; logic [15:0] d; } wr_t;
    rsp_t rq[$];
    wr_t  wq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor
    logic ack_prev = 1'b0;
    int   busy_cnt = 0;
    always @(negedge clk_49m) begin
        if (!reset) begin
            busy_cnt = 0;
            ack_prev = ack;
        end else begin
            if (mem_we) begin
                if (wq.size() == 0) flag("unexpected_mem_we");
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.a));
                    chk("wr_be",   32'(mem_be),   32'(w.be));
                    chk("wr_data", 32'(mem_d),    32'(w.d));
                end
            end
            if (ack !== ack_prev) begin
                if (rq.size() == 0) flag("unexpected_ack");
                else begin
                    rsp_t r;
                    r = rq.pop_front();
                    chk("rsp_q",    32'(q),         32'(r.q));
                    chk("rsp_lat",  32'(cyc - r.det), 32'(r.lat));
                    chk("rsp_busy", 32'(busy_cnt),  32'(r.lat));
                end
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end
            ack_prev = ack;
        end
    end

    task automatic wait_ack();
        logic a0;
        int   k;
        a0 = ack;
        for (k = 0; k < 50; k++) begin
            @(posedge clk_49m);
            #1;
            if (ack != a0) break;
        end
        if (k == 50) flag("ack_timeout");
    endtask

    // Called #1 after a rising edge; the next edge is the detect edge.
    task automatic issue(input logic w, input logic [14:0] ad, input logic [1:0] s,
                         input logic [15:0] wd, input logic [15:0] eq);
        rsp_t r;
        wr_t  x;
        a = ad; ds = s; we = w; d = wd;
        if (w) begin
            x.a = ad; x.be = s; x.d = wd;
            wq.push_back(x);
        end
        r.q = eq; r.lat = w ? WR_LAT : L + 2; r.det = cyc + 1;
        rq.push_back(r);
        req = ~req;
        wait_ack();
    endtask

    typedef struct { logic w; logic [14:0] a; logic [1:0] ds; logic [15:0] d;
                     logic [15:0] q_def; logic [15:0] q_rb; } vec_t;
    vec_t vecs [8] = '{
        '{1'b1, 15'h0123, 2'b11, 16'hBEEF, 16'h0000, 16'hBEEF},
        '{1'b0, 15'h0123, 2'b11, 16'h0000, 16'hBEEF, 16'hBEEF},
        '{1'b1, 15'h0123, 2'b10, 16'h5A5A, 16'hBEEF, 16'h5AEF},
        '{1'b0, 15'h0123, 2'b00, 16'h0000, 16'h5AEF, 16'h5AEF},
        '{1'b1, 15'h0123, 2'b00, 16'h1111, 16'h5AEF, 16'h5AEF},
        '{1'b0, 15'h0123, 2'b01, 16'h0000, 16'h5AEF, 16'h5AEF},
        '{1'b1, 15'h0040, 2'b11, 16'h1234, 16'h5AEF, 16'h1234},
        '{1'b0, 15'h0040, 2'b11, 16'h0000, 16'h1234, 16'h1234}
    };

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t r;
        reset = 1'b0; req = 1'b0; a = '0; ds = '0; we = 1'b0; d = '0;
        repeat (3) @(posedge clk_49m);
        #1;
        chk("rst_ack",      32'(ack),      0);
        chk("rst_q",        32'(q),        0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_we",   32'(mem_we),   0);
        chk("rst_mem_be",   32'(mem_be),   0);
        chk("rst_mem_d",    32'(mem_d),    0);
        reset = 1'b1;
        @(posedge clk_49m);
        #1;

        for (int i = 0; i < 8; i++)
            issue(vecs[i].w, vecs[i].a, vecs[i].ds, vecs[i].d, RB ? vecs[i].q_rb : vecs[i].q_def);

        // Back-to-back reads, each toggle the cycle after the previous ack.
        for (int i = 0; i < 8; i++)
            issue(1'b0, 15'h0200 + 15'(i), 2'b11, 16'h0000, TBL[i]);

        chk("ack_parity", 32'(ack), 0);
        chk("ack_eq_req", 32'(ack), 32'(req));
        chk("idle_busy",  32'(busy), 0);

        // Reset while a read sits in WAIT; req stays 1 across release.
        a = 15'h0200; we = 1'b0; ds = 2'b11;
        req = ~req;
        @(posedge clk_49m); #1;
        @(posedge clk_49m); #1;
        reset = 1'b0;
        #1;
        chk("midrst_ack",    32'(ack),    0);
        chk("midrst_busy",   32'(busy),   0);
        chk("midrst_q",      32'(q),      0);
        chk("midrst_mem_we", 32'(mem_we), 0);
        repeat (2) @(posedge clk_49m);
        #1;
        chk("midrst_hold_we", 32'(mem_we), 0);
        r.q = TBL[0]; r.lat = L + 2; r.det = cyc + 1;
        rq.push_back(r);
        reset = 1'b1;
        wait_ack();
        chk("post_rst_ack", 32'(ack), 1);

        repeat (3) @(posedge clk_49m);
        #1;
        chk("rsp_queue_drained", 32'(rq.size()), 0);
        chk("wr_queue_drained",  32'(wq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
